// File: rtl/tri_setup_bbox_if.sv
// Triangle setup bus.
// Upstream side: vertex positions and depths with valid_in/ready_out/short_circuit_in.
// Downstream side: the setup record with valid_out/ready_in.
//
// Handshake rule, for both directions: a transfer happens on a rising clock edge
// where valid and ready are both high. While valid is high and ready is low, the
// sender holds valid and its payload stable. The receiver may raise or drop ready
// at any time.
//
// Modports:
//   slave  - the setup block: consumes vertices and produces records.
//   master - the environment: the vertex producer plus the record consumer.
interface tri_setup_bbox_if #(
  parameter int XW = 18,  // vertex x width
  parameter int YW = 20,  // vertex y width
  parameter int ZW = 16,  // depth width
  parameter int PW = 10   // pixel coordinate width
);
  localparam int AW = XW + YW + 3;

  logic                   valid_in;
  logic                   ready_out;
  logic                   short_circuit_in;
  logic [2:0][XW-1:0]     x_in;
  logic [2:0][YW-1:0]     y_in;
  logic [2:0][ZW-1:0]     z_in;
  logic                   valid_out;
  logic                   ready_in;
  logic [PW-1:0]          xmin;
  logic [PW-1:0]          xmax;
  logic [PW-1:0]          ymin;
  logic [PW-1:0]          ymax;
  logic signed [AW-1:0]   area2;
  logic [ZW-1:0]          z_min;

  modport slave (
    input  valid_in, short_circuit_in, x_in, y_in, z_in, ready_in,
    output ready_out, valid_out, xmin, xmax, ymin, ymax, area2, z_min
  );

  modport master (
    output valid_in, short_circuit_in, x_in, y_in, z_in, ready_in,
    input  ready_out, valid_out, xmin, xmax, ymin, ymax, area2, z_min
  );
endinterface

// File: rtl/tri_setup_bbox.sv
// Triangle setup and bounding-box stage.
// The block accepts one projected triangle at a time and computes its signed
// doubled area with one shared multiplier.
// It also computes the clamped pixel bounding box.
// It culls triangles that are degenerate, back-facing (optional) or fully off-screen.
// Each surviving triangle becomes a registered record for the rasterizer.
//
// Ports:
//   clk_in     - clock
//   rst_in     - synchronous active-high reset
//   bus        - tri_setup_bbox_if.slave (vertex input plus record output)
//   cull_count - count of culled triangles; wraps
//   drop_count - count of triangles discarded through short_circuit_in; wraps
//   state_dbg  - current FSM state encoding
module tri_setup_bbox #(
  parameter int VIEWPORT_H_POSITION_WIDTH = 18,
  parameter int VIEWPORT_W_POSITION_WIDTH = 20,
  parameter int ZWIDTH    = 16,
  parameter int POS_FRAC  = 8,
  parameter int HALF_W    = 160,
  parameter int HALF_H    = 120,
  parameter int PIX_WIDTH = 10,
  parameter bit CULL_BACK = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  tri_setup_bbox_if.slave bus,
  output logic [15:0] cull_count,
  output logic [15:0] drop_count,
  output logic [2:0]  state_dbg
);
  localparam int XW  = VIEWPORT_H_POSITION_WIDTH;
  localparam int YW  = VIEWPORT_W_POSITION_WIDTH;
  localparam int MW  = XW + YW + 2;  // exact width of one (XW+1)x(YW+1) product
  localparam int AW  = MW + 1;       // difference of two products
  localparam int PXW = XW + 2;       // pixel x before clamping, with the screen offset
  localparam int PYW = YW + 2;

  localparam logic signed [PXW-1:0] X_OFF = PXW'(HALF_W);
  localparam logic signed [PYW-1:0] Y_OFF = PYW'(HALF_H);
  localparam logic signed [PXW-1:0] X_LIM = PXW'(2 * HALF_W - 1);
  localparam logic signed [PYW-1:0] Y_LIM = PYW'(2 * HALF_H - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DIFF = 3'd1, S_MUL0 = 3'd2,
    S_MUL1 = 3'd3, S_DECIDE = 3'd4, S_EMIT = 3'd5
  } state_t;

  state_t state;
  assign state_dbg = state;

  logic signed [XW-1:0]  x_r  [3];
  logic signed [YW-1:0]  y_r  [3];
  logic [ZWIDTH-1:0]     z_r  [3];
  logic signed [PXW-1:0] px_r [3];
  logic signed [PYW-1:0] py_r [3];
  logic signed [XW:0]    dx1, dx2;
  logic signed [YW:0]    dy1, dy2;
  logic signed [MW-1:0]  prod0, prod1;

  // One multiplier serves both cross-product terms: MUL0 forms dx1*dy2 and MUL1 forms dx2*dy1.
  logic signed [XW:0]   mul_a;
  logic signed [YW:0]   mul_b;
  logic signed [MW-1:0] product;
  assign mul_a   = (state == S_MUL0) ? dx1 : dx2;
  assign mul_b   = (state == S_MUL0) ? dy2 : dy1;
  assign product = MW'(mul_a) * MW'(mul_b);

  logic signed [AW-1:0] area_c;
  assign area_c = AW'(prod0) - AW'(prod1);

  // Bounding box over the unclamped pixel positions. The off-screen test uses these values.
  logic signed [PXW-1:0] px_lo, px_hi;
  logic signed [PYW-1:0] py_lo, py_hi;
  logic [ZWIDTH-1:0]     z_lo;
  logic                  cull_c;
  logic [PIX_WIDTH-1:0]  xmin_c, xmax_c, ymin_c, ymax_c;

  always_comb begin
    px_lo = px_r[0];
    px_hi = px_r[0];
    py_lo = py_r[0];
    py_hi = py_r[0];
    z_lo  = z_r[0];
    for (int i = 1; i < 3; i++) begin
      if (px_r[i] < px_lo) px_lo = px_r[i];
      if (px_r[i] > px_hi) px_hi = px_r[i];
      if (py_r[i] < py_lo) py_lo = py_r[i];
      if (py_r[i] > py_hi) py_hi = py_r[i];
      if (z_r[i] < z_lo)   z_lo  = z_r[i];
    end

    cull_c = (area_c == '0) || (CULL_BACK && (area_c < 0)) ||
             (px_hi < 0) || (px_lo > X_LIM) ||
             (py_hi < 0) || (py_lo > Y_LIM);

    xmin_c = (px_lo < 0) ? '0 : (px_lo > X_LIM) ? PIX_WIDTH'(X_LIM) : PIX_WIDTH'(px_lo);
    xmax_c = (px_hi < 0) ? '0 : (px_hi > X_LIM) ? PIX_WIDTH'(X_LIM) : PIX_WIDTH'(px_hi);
    ymin_c = (py_lo < 0) ? '0 : (py_lo > Y_LIM) ? PIX_WIDTH'(Y_LIM) : PIX_WIDTH'(py_lo);
    ymax_c = (py_hi < 0) ? '0 : (py_hi > Y_LIM) ? PIX_WIDTH'(Y_LIM) : PIX_WIDTH'(py_hi);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      bus.ready_out <= 1'b1;
      bus.valid_out <= 1'b0;
      bus.xmin      <= '0;
      bus.xmax      <= '0;
      bus.ymin      <= '0;
      bus.ymax      <= '0;
      bus.area2     <= '0;
      bus.z_min     <= '0;
      cull_count    <= '0;
      drop_count    <= '0;
      dx1           <= '0;
      dx2           <= '0;
      dy1           <= '0;
      dy2           <= '0;
      prod0         <= '0;
      prod1         <= '0;
      for (int i = 0; i < 3; i++) begin
        x_r[i]  <= '0;
        y_r[i]  <= '0;
        z_r[i]  <= '0;
        px_r[i] <= '0;
        py_r[i] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.valid_in && bus.ready_out) begin
            if (bus.short_circuit_in) begin
              drop_count <= drop_count + 16'd1;
            end else begin
              for (int i = 0; i < 3; i++) begin
                x_r[i] <= $signed(bus.x_in[i]);
                y_r[i] <= $signed(bus.y_in[i]);
                z_r[i] <= bus.z_in[i];
              end
              bus.ready_out <= 1'b0;
              state         <= S_DIFF;
            end
          end
        end
        S_DIFF: begin
          dx1 <= (XW+1)'(x_r[1]) - (XW+1)'(x_r[0]);
          dx2 <= (XW+1)'(x_r[2]) - (XW+1)'(x_r[0]);
          dy1 <= (YW+1)'(y_r[1]) - (YW+1)'(y_r[0]);
          dy2 <= (YW+1)'(y_r[2]) - (YW+1)'(y_r[0]);
          // Arithmetic shift floors the fixed-point position toward minus infinity.
          for (int i = 0; i < 3; i++) begin
            px_r[i] <= (PXW'(x_r[i]) >>> POS_FRAC) + X_OFF;
            py_r[i] <= (PYW'(y_r[i]) >>> POS_FRAC) + Y_OFF;
          end
          state <= S_MUL0;
        end
        S_MUL0: begin
          prod0 <= product;
          state <= S_MUL1;
        end
        S_MUL1: begin
          prod1 <= product;
          state <= S_DECIDE;
        end
        S_DECIDE: begin
          if (cull_c) begin
            cull_count    <= cull_count + 16'd1;
            bus.ready_out <= 1'b1;
            state         <= S_IDLE;
          end else begin
            bus.area2     <= area_c;
            bus.xmin      <= xmin_c;
            bus.xmax      <= xmax_c;
            bus.ymin      <= ymin_c;
            bus.ymax      <= ymax_c;
            bus.z_min     <= z_lo;
            bus.valid_out <= 1'b1;
            state         <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.ready_in) begin
            bus.valid_out <= 1'b0;
            bus.ready_out <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          bus.valid_out <= 1'b0;
          bus.ready_out <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tri_setup_bbox.sv
// Bench for tri_setup_bbox.
// Two instances receive the same stimulus. dut_a culls back faces and dut_b keeps them.
// A reference model computes the expected record for each instance. Each instance has
// its own expected queue, and records are checked as they leave each instance.
module tb_tri_setup_bbox;
  localparam int XW = 18, YW = 20, ZW = 16, PW = 10;
  localparam int REC_W = (XW + YW + 3) + 4 * PW + ZW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              valid_in = 1'b0, sc = 1'b0, ready_in = 1'b1;
  logic [2:0][XW-1:0] x_drv = '0;
  logic [2:0][YW-1:0] y_drv = '0;
  logic [2:0][ZW-1:0] z_drv = '0;

  tri_setup_bbox_if #(.XW(XW), .YW(YW), .ZW(ZW), .PW(PW)) ifa ();
  tri_setup_bbox_if #(.XW(XW), .YW(YW), .ZW(ZW), .PW(PW)) ifb ();

  assign ifa.valid_in = valid_in;  assign ifb.valid_in = valid_in;
  assign ifa.short_circuit_in = sc; assign ifb.short_circuit_in = sc;
  assign ifa.ready_in = ready_in;  assign ifb.ready_in = ready_in;
  assign ifa.x_in = x_drv;  assign ifb.x_in = x_drv;
  assign ifa.y_in = y_drv;  assign ifb.y_in = y_drv;
  assign ifa.z_in = z_drv;  assign ifb.z_in = z_drv;

  logic [15:0] cull_a, drop_a, cull_b, drop_b;
  logic [2:0]  st_a, st_b;

  tri_setup_bbox #(.CULL_BACK(1'b1)) dut_a (
    .clk_in(clk), .rst_in(rst), .bus(ifa),
    .cull_count(cull_a), .drop_count(drop_a), .state_dbg(st_a));
  tri_setup_bbox #(.CULL_BACK(1'b0)) dut_b (
    .clk_in(clk), .rst_in(rst), .bus(ifb),
    .cull_count(cull_b), .drop_count(drop_b), .state_dbg(st_b));

  int n_cmp = 0, n_err = 0;
  logic [REC_W-1:0] exp_qa[$], exp_qb[$];
  int exp_cull_a = 0, exp_cull_b = 0, exp_drop = 0;
  int tx[3], ty[3], tz[3];  // raw fixed-point positions and depths

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int floor256(input int v);
    int q;
    q = v / 256;
    if (v < 0 && (v % 256) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic void model(input bit cull_back, output bit culled, output logic [REC_W-1:0] rec);
    longint area;
    int px[3], py[3];
    int xl, xh, yl, yh, zl;
    logic [40:0] a41;
    area = longint'(tx[1] - tx[0]) * longint'(ty[2] - ty[0])
         - longint'(tx[2] - tx[0]) * longint'(ty[1] - ty[0]);
    for (int i = 0; i < 3; i++) begin
      px[i] = floor256(tx[i]) + 160;
      py[i] = floor256(ty[i]) + 120;
    end
    xl = px[0]; xh = px[0]; yl = py[0]; yh = py[0]; zl = tz[0];
    for (int i = 1; i < 3; i++) begin
      if (px[i] < xl) xl = px[i];
      if (px[i] > xh) xh = px[i];
      if (py[i] < yl) yl = py[i];
      if (py[i] > yh) yh = py[i];
      if (tz[i] < zl) zl = tz[i];
    end
    culled = (area == 0) || (cull_back && area < 0) ||
             (xh < 0) || (xl > 319) || (yh < 0) || (yl > 239);
    a41 = area[40:0];
    rec = {a41, PW'(clampi(xl, 319)), PW'(clampi(xh, 319)),
           PW'(clampi(yl, 239)), PW'(clampi(yh, 239)), ZW'(zl)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = ifa.ready_out && ifb.ready_out;
    end
    if (!ok) check("ready_wait_timeout", 0, 1);
  endtask

  task automatic set_tri_px(input int x0, y0, x1, y1, x2, y2, z0, z1, z2);
    tx[0] = x0 * 256; ty[0] = y0 * 256; tz[0] = z0;
    tx[1] = x1 * 256; ty[1] = y1 * 256; tz[1] = z1;
    tx[2] = x2 * 256; ty[2] = y2 * 256; tz[2] = z2;
  endtask

  task automatic send_tri(input bit abort);
    bit c;
    logic [REC_W-1:0] r;
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      x_drv[i] = XW'(tx[i]);
      y_drv[i] = YW'(ty[i]);
      z_drv[i] = ZW'(tz[i]);
    end
    sc = abort;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sc = 1'b0;
    if (abort) exp_drop++;
    else begin
      model(1'b1, c, r);
      if (c) exp_cull_a++; else exp_qa.push_back(r);
      model(1'b0, c, r);
      if (c) exp_cull_b++; else exp_qb.push_back(r);
    end
  endtask

  task automatic settle();
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cull_a"}, cull_a, 16'(exp_cull_a));
    check({tag, "_cull_b"}, cull_b, 16'(exp_cull_b));
    check({tag, "_drop_a"}, drop_a, 16'(exp_drop));
    check({tag, "_drop_b"}, drop_b, 16'(exp_drop));
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && ifa.valid_out && ready_in) begin
      if (exp_qa.size() == 0) check("a_unexpected_record", 1, 0);
      else check("a_record", {ifa.area2, ifa.xmin, ifa.xmax, ifa.ymin, ifa.ymax, ifa.z_min},
                 exp_qa.pop_front());
    end
    if (!rst && ifb.valid_out && ready_in) begin
      if (exp_qb.size() == 0) check("b_unexpected_record", 1, 0);
      else check("b_record", {ifb.area2, ifb.xmin, ifb.xmax, ifb.ymin, ifb.ymax, ifb.z_min},
                 exp_qb.pop_front());
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    logic [REC_W-1:0] snap;
    bit seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready_out", ifa.ready_out, 1);
    check("rst_valid_out", ifa.valid_out, 0);
    check("rst_record", {ifa.area2, ifa.xmin, ifa.xmax, ifa.ymin, ifa.ymax, ifa.z_min}, 0);
    check("rst_state", st_a, 0);
    check_counters("rst");

    // CCW triangle: check the record and the accept-to-valid latency.
    set_tri_px(0, 0, 10, 0, 0, 10, 5, 3, 9);
    send_tri(1'b0);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (ifa.valid_out) lat = k;
    end
    check("ccw_latency", lat, 4);
    settle();
    check_counters("ccw");

    // Swapped winding: back face, culled only by dut_a.
    set_tri_px(0, 0, 0, 10, 10, 0, 5, 3, 9);
    send_tri(1'b0);
    settle();
    check_counters("cw");

    // Collinear: culled in DECIDE, so ready_out returns at the DECIDE edge.
    set_tri_px(0, 0, 5, 5, 10, 10, 1, 2, 3);
    send_tri(1'b0);
    repeat (3) @(posedge clk);
    #1 check("collinear_busy_in_decide", ifa.ready_out, 0);
    @(posedge clk);
    #1 check("collinear_ready_after_decide", ifa.ready_out, 1);
    settle();
    check_counters("collinear");

    // Entirely right of the screen.
    set_tri_px(200, 0, 220, 0, 200, 10, 1, 2, 3);
    send_tri(1'b0);
    settle();
    check_counters("offscreen");

    // Span from -300 to 10 px: xmin clamps to 0.
    set_tri_px(-300, 0, 10, 0, -300, 10, 7, 8, 6);
    send_tri(1'b0);
    settle();

    // Hold the record in EMIT with ready_in low while valid_in toggles upstream.
    ready_in = 1'b0;
    set_tri_px(0, 0, 10, 0, 0, 10, 4, 4, 2);
    send_tri(1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk);
      #1 seen = ifa.valid_out;
    end
    check("stall_valid_seen", seen, 1);
    snap = {ifa.area2, ifa.xmin, ifa.xmax, ifa.ymin, ifa.ymax, ifa.z_min};
    for (int k = 0; k < 6; k++) begin
      valid_in = 1'b1;
      x_drv[0] = XW'($urandom_range(0, 4095));
      @(posedge clk);
      #1;
      check("stall_record", {ifa.area2, ifa.xmin, ifa.xmax, ifa.ymin, ifa.ymax, ifa.z_min}, snap);
      check("stall_valid", ifa.valid_out, 1);
      check("stall_ready_out", ifa.ready_out, 0);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk);
    #1 check("stall_released", ifa.valid_out, 0);
    check("stall_ready_back", ifa.ready_out, 1);
    settle();

    // Abort: counted as a drop and never processed.
    set_tri_px(0, 0, 10, 0, 0, 10, 5, 3, 9);
    send_tri(1'b1);
    settle();
    check_counters("abort");

    // Random triangles with fractional positions, some partially off-screen.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 3; i++) begin
        tx[i] = int'($urandom_range(0, 204800)) - 102400;
        ty[i] = int'($urandom_range(0, 300000)) - 150000;
        tz[i] = int'($urandom_range(0, 65535));
      end
      send_tri(1'b0);
    end
    settle();
    for (int k = 0; k < 100 && (exp_qa.size() != 0 || exp_qb.size() != 0); k++)
      @(posedge clk);
    #1;
    check("drain_qa", exp_qa.size(), 0);
    check("drain_qb", exp_qb.size(), 0);
    check_counters("random");

    // Reset during MUL1 abandons the triangle and clears the counters.
    set_tri_px(0, 0, 10, 0, 0, 10, 5, 3, 9);
    send_tri(1'b0);
    repeat (2) @(posedge clk);
    #1 check("mid_state_mul1", st_a, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_qa.delete();
    exp_qb.delete();
    exp_cull_a = 0; exp_cull_b = 0; exp_drop = 0;
    check("mid_rst_state", st_a, 0);
    check("mid_rst_ready", ifa.ready_out, 1);
    check("mid_rst_valid", ifa.valid_out, 0);
    check_counters("mid_rst");
    settle();
    check("mid_rst_no_emit", ifa.valid_out | ifb.valid_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
